keypad_scanner: RTL and testbench

Scan-multiplexed 4x4 matrix keypad reader. This is the input-side counterpart of the score display's column-multiplexed segment driver: it drives one column low at a time and reads the row lines. Raw presses are debounced and encoded to a 4-bit key code. The code is held in a one-deep buffer with a valid/ack handshake toward game control logic.

---
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/keypad_scanner.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin and consumer handshake bundle.
// master: the scanner; slave: the keypad matrix / game control side.
interface keypad_scanner_if;
  logic [3:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_ACK;
  logic       KEY_HELD;
  logic       OVERRUN;

  modport master (
    input  KEY_ROW, KEY_ACK,
    output KEY_COL, KEY_CODE, KEY_VALID, KEY_HELD, OVERRUN
  );

  modport slave (
    output KEY_ROW, KEY_ACK,
    input  KEY_COL, KEY_CODE, KEY_VALID, KEY_HELD, OVERRUN
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 column-multiplexed keypad reader: scan, debounce, encode, one-deep buffered handshake.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000
`endif
) (
  input logic              CLK,
  input logic              RST,
  keypad_scanner_if.master kp
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e          state_q, state_d;
  logic [3:0]      row_s1_q, row_s2_q;
  logic [1:0]      col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      key_col_q, key_col_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            overrun_q, overrun_d;
  logic            dlv;
  logic [1:0]      row_idx;
  logic            ack;

  wire [3:0] rs = row_s2_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  // Lowest low row wins when several rows are pulled down in the frozen column.
  always_comb begin
    row_idx = 2'd3;
    if (!pat_q[0])      row_idx = 2'd0;
    else if (!pat_q[1]) row_idx = 2'd1;
    else if (!pat_q[2]) row_idx = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dlv     = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SLOT_LAST) begin
          if (rs != 4'hF) begin
            pat_d   = rs;
            state_d = DEBOUNCE;
            cnt_d   = CW'(1);           // the entry sample is the first match
          end else begin
            col_d = col_q + 2'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          dlv     = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (rs != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        col_d   = '0;
        cnt_d   = '0;
      end
    endcase

`ifdef KEYPAD_AUTOREPEAT_EN
    // Down-counter to the next repeat; reloaded on HELD entry, idle elsewhere.
    rpt_d = '0;
    if (state_q == HELD && state_d == HELD) begin
      if (rpt_q == '0) begin
        dlv   = 1'b1;
        rpt_d = RW'(REPEAT_PERIOD - 1);
      end else begin
        rpt_d = rpt_q - RW'(1);
      end
    end else if (state_d == HELD) begin
      rpt_d = RW'(REPEAT_DELAY - 1);
    end
`endif
  end

  // One-deep buffer: an ack in the delivery cycle makes room, otherwise a full buffer drops.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    ack         = kp.KEY_ACK & key_valid_q;
    if (dlv) begin
      if (!key_valid_q || ack) begin
        key_code_d  = {row_idx, col_q};
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    key_held_d = (state_d == HELD);
    key_col_d  = ~(4'b0001 << col_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SCAN;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      col_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= 4'hF;
      key_col_q   <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_s1_q    <= kp.KEY_ROW;
      row_s2_q    <= row_s1_q;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      key_col_q   <= key_col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign kp.KEY_COL   = key_col_q;
  assign kp.KEY_CODE  = key_code_q;
  assign kp.KEY_VALID = key_valid_q;
  assign kp.KEY_HELD  = key_held_q;
  assign kp.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 4x4 matrix model drives rows from the column drives,
// expected key codes go through a scoreboard queue and are checked on delivery.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  rowv;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic [3:0]  one = 4'b0001;
  logic        seen;
  int          errors = 0;
  int          checks = 0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(8)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(50),
    .REPEAT_PERIOD(20)
`endif
  ) dut (
    .CLK(clk),
    .RST(rst),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rowv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.KEY_COL[c]) rowv[r] = 1'b0;
  end
  assign kp.KEY_ROW = rowv;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (kp.KEY_VALID !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({tag, " valid wait"}, {7'd0, kp.KEY_VALID}, 8'd1);
  endtask

  task automatic wait_held(input string tag, input logic v);
    int n = 0;
    while (kp.KEY_HELD !== v && n < 300) begin @(negedge clk); n++; end
    check({tag, " held wait"}, {7'd0, kp.KEY_HELD}, {7'd0, v});
  endtask

  task automatic wait_col(input string tag, input logic [3:0] c);
    int n = 0;
    while (kp.KEY_COL !== c && n < 100) begin @(negedge clk); n++; end
    check({tag, " col wait"}, {4'd0, kp.KEY_COL}, {4'd0, c});
  endtask

  task automatic pop_check(input string tag);
    exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    check({tag, " code"}, {4'd0, kp.KEY_CODE}, {4'd0, exp_code});
  endtask

  task automatic ack_pulse();
    kp.KEY_ACK = 1'b1;
    @(negedge clk);
    kp.KEY_ACK = 1'b0;
  endtask

  initial begin
    kp.KEY_ACK = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // reset state and idle column walk
    check("rst code",    {4'd0, kp.KEY_CODE}, 8'd0);
    check("rst valid",   {7'd0, kp.KEY_VALID}, 8'd0);
    check("rst held",    {7'd0, kp.KEY_HELD}, 8'd0);
    check("rst overrun", {7'd0, kp.OVERRUN}, 8'd0);
    for (int k = 0; k <= 16; k++) begin
      if (k % 4 == 0) check("idle col", {4'd0, kp.KEY_COL}, {4'd0, ~(one << ((k / 4) % 4))});
      @(negedge clk);
    end

    // key 9 pressed, no ack; release resumes at col2
    keys[9] = 1'b1; exp_q.push_back(4'd9);
    wait_valid("t2");
    pop_check("t2");
    check("t2 held", {7'd0, kp.KEY_HELD}, 8'd1);
    keys = '0;
    wait_held("t2 rel", 1'b0);
    check("t2 next col", {4'd0, kp.KEY_COL}, 8'b1011);
    check("t2 still valid", {7'd0, kp.KEY_VALID}, 8'd1);
    ack_pulse();
    check("t2 ack clears", {7'd0, kp.KEY_VALID}, 8'd0);

    // bouncing key 3, then stable: one delivery
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      repeat (3) begin @(negedge clk); seen |= kp.KEY_VALID; end
    end
    check("t3 no bounce dlv", {7'd0, seen}, 8'd0);
    keys[3] = 1'b1; exp_q.push_back(4'd3);
    wait_valid("t3");
    pop_check("t3");
    ack_pulse();
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= kp.KEY_VALID; end
    check("t3 single dlv", {7'd0, seen}, 8'd0);
    keys = '0;
    wait_held("t3 rel", 1'b0);

    // overrun: key 5 unconsumed, key 10 dropped
    keys[5] = 1'b1; exp_q.push_back(4'd5);
    wait_valid("t4");
    pop_check("t4");
    keys = '0;
    wait_held("t4 rel5", 1'b0);
    keys[10] = 1'b1;
    wait_held("t4 hold10", 1'b1);
    check("t4 code kept", {4'd0, kp.KEY_CODE}, 8'd5);
    check("t4 overrun", {7'd0, kp.OVERRUN}, 8'd1);
    keys = '0;
    wait_held("t4 rel10", 1'b0);
    ack_pulse();
    check("t4 ack valid", {7'd0, kp.KEY_VALID}, 8'd0);
    check("t4 ack overrun", {7'd0, kp.OVERRUN}, 8'd0);

    // ack coincident with delivery of key 15 while key 0 is still buffered
    keys[0] = 1'b1; exp_q.push_back(4'd0);
    wait_valid("t5");
    pop_check("t5");
    keys = '0;
    wait_held("t5 rel0", 1'b0);
    wait_col("t5", 4'b0111);
    keys[15] = 1'b1;
    // column switched at edge e0; sample at e0+3, delivery lands on edge e0+11
    repeat (10) @(negedge clk);
    check("t5 pre code", {4'd0, kp.KEY_CODE}, 8'd0);
    check("t5 pre valid", {7'd0, kp.KEY_VALID}, 8'd1);
    kp.KEY_ACK = 1'b1;
    @(negedge clk);
    kp.KEY_ACK = 1'b0;
    check("t5 coinc code", {4'd0, kp.KEY_CODE}, 8'd15);
    check("t5 coinc valid", {7'd0, kp.KEY_VALID}, 8'd1);
    check("t5 coinc overrun", {7'd0, kp.OVERRUN}, 8'd0);
    keys = '0;
    wait_held("t5 rel15", 1'b0);
    ack_pulse();
    keys[4] = 1'b1; keys[12] = 1'b1; exp_q.push_back(4'd4);
    wait_valid("t5 multi");
    pop_check("t5 multi");
    keys = '0;
    wait_held("t5 rel4", 1'b0);
    ack_pulse();

    // reset during debounce, key still held afterwards
    wait_col("t6a", 4'b0111);
    wait_col("t6b", 4'b1101);
    keys[9] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 rst col", {4'd0, kp.KEY_COL}, 8'b1110);
    check("t6 rst code", {4'd0, kp.KEY_CODE}, 8'd0);
    check("t6 rst valid", {7'd0, kp.KEY_VALID}, 8'd0);
    check("t6 rst held", {7'd0, kp.KEY_HELD}, 8'd0);
    check("t6 rst overrun", {7'd0, kp.OVERRUN}, 8'd0);
    exp_q.push_back(4'd9);
    wait_valid("t6");
    pop_check("t6");
    ack_pulse();
`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int n;
      int exp_gap;
      for (int r = 0; r < 3; r++) begin
        n = 1;
        exp_gap = (r == 0) ? 50 : 20;
        while (kp.KEY_VALID !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("t6 repeat gap", 8'(n), 8'(exp_gap));
        check("t6 repeat code", {4'd0, kp.KEY_CODE}, 8'd9);
        ack_pulse();
      end
    end
`else
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= kp.KEY_VALID; end
    check("t6 single dlv", {7'd0, seen}, 8'd0);
`endif
    keys = '0;
    wait_held("t6 rel", 1'b0);
    check("sb drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
